// File: rtl/phase_sequencer.sv
// Phase sequencer: drives fetch/exec1/exec2/exec3 strobes, holds the IR and counts retired instructions.
// Optional single-step WAIT state is compiled in with `define PHASE_STEP_EN.
module phase_sequencer #(
    parameter int          IW      = 16,
    parameter int          CNT_W   = 16,
    parameter logic [4:0]  STP_OPC = 5'b11110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    rom_q,
    input  logic             extra,
    input  logic             extra2,
    input  logic             stall,
    input  logic             step_mode,
    input  logic             step,
    output logic [IW-1:0]    instr,
    output logic             fetch,
    output logic             exec1,
    output logic             exec2,
    output logic             exec3,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_EXEC1 = 3'd1,
        S_EXEC2 = 3'd2,
        S_EXEC3 = 3'd3,
        S_HALT  = 3'd4
`ifdef PHASE_STEP_EN
        , S_WAIT = 3'd5
`endif
    } state_t;

    state_t state;
    state_t state_next;
    state_t idle_state;
    logic   ir_load;
    logic   retire;
    logic   is_stp;

    assign is_stp = (instr[15:11] == STP_OPC);

`ifdef PHASE_STEP_EN
    logic step_q;
    logic step_rise;

    assign step_rise  = step & ~step_q;
    assign idle_state = step_mode ? S_WAIT : S_FETCH;
`else
    logic unused_step_inputs;

    assign unused_step_inputs = step_mode | step;
    assign idle_state         = S_FETCH;
`endif

    // stall is a plain hold request: while high nothing advances and no strobe fires.
    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        retire     = 1'b0;
        if (!stall) begin
            case (state)
                S_FETCH: begin
                    state_next = S_EXEC1;
                    ir_load    = 1'b1;
                end
                S_EXEC1: begin
                    if (is_stp) begin
                        state_next = S_HALT;
                    end else if (extra) begin
                        state_next = S_EXEC2;
                    end else begin
                        state_next = idle_state;
                        retire     = 1'b1;
                    end
                end
                S_EXEC2: begin
                    if (extra2) begin
                        state_next = S_EXEC3;
                    end else begin
                        state_next = idle_state;
                        retire     = 1'b1;
                    end
                end
                S_EXEC3: begin
                    state_next = idle_state;
                    retire     = 1'b1;
                end
                S_HALT: begin
                    state_next = S_HALT;
                end
`ifdef PHASE_STEP_EN
                S_WAIT: begin
                    if (!step_mode || step_rise) begin
                        state_next = S_FETCH;
                    end
                end
`endif
                default: begin
                    state_next = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= idle_state;
            instr       <= '0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (ir_load) begin
                instr <= rom_q;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

`ifdef PHASE_STEP_EN
    // Edge register runs in every state so an edge outside WAIT is simply consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`endif

    assign fetch  = (state == S_FETCH) & ~stall;
    assign exec1  = (state == S_EXEC1) & ~stall;
    assign exec2  = (state == S_EXEC2) & ~stall;
    assign exec3  = (state == S_EXEC3) & ~stall;
    assign halted = (state == S_HALT);

endmodule
